// File: rtl/e203_dsp_pkg.sv
// Shared constants and types for the DSP-ALU Booth multiplier responder.
package e203_dsp_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_e;

  function automatic booth_op_e booth_dec(input logic b0, input logic prev);
    case ({b0, prev})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/e203_dsp_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand, then
// arithmetic right shift of {acc, mplr, prev}.
module e203_dsp_booth_step
  import e203_dsp_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W+1:0] i_acc,
  input  logic [W:0]   i_mplr,
  input  logic         i_prev,
  input  logic [W:0]   i_mcand,
  output logic [W+1:0] o_acc,
  output logic [W:0]   o_mplr,
  output logic         o_prev
);

  logic [W+1:0] w_mc_ext;
  logic [W+1:0] w_sum;
  booth_op_e    w_op;

  // acc carries one guard bit so the add/sub can never overflow
  assign w_mc_ext = {i_mcand[W], i_mcand};
  assign w_op     = booth_dec(i_mplr[0], i_prev);

  always_comb begin
    w_sum = i_acc;
    case (w_op)
      ADD:     w_sum = i_acc + w_mc_ext;
      SUB:     w_sum = i_acc - w_mc_ext;
      default: w_sum = i_acc;
    endcase
  end

  assign o_acc  = {w_sum[W+1], w_sum[W+1:1]};
  assign o_mplr = {w_sum[0], i_mplr[W:1]};
  assign o_prev = i_mplr[0];

endmodule

// File: rtl/e203_exu_dsp_mul_srv.sv
// Iterative 33x33 signed Booth multiplier serving DSP-ALU requests; returns the
// low 2*XLEN product bits with the request tag after XLEN+1 steps.
module e203_exu_dsp_mul_srv
  import e203_dsp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN:0]     req_rs1,
  input  logic [XLEN:0]     req_rs2,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*XLEN-1:0] rsp_res,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  state_e             r_state;
  state_e             w_state_n;
  logic [CNT_W-1:0]   r_cnt;
  logic [XLEN+1:0]    r_acc;
  logic [XLEN:0]      r_mplr;
  logic               r_prev;
  logic [XLEN:0]      r_mcand;
  logic [TAG_W-1:0]   r_tag;
  logic [2*XLEN-1:0]  r_res;
  logic               r_rsp_valid;

  logic [XLEN+1:0]    w_acc_n;
  logic [XLEN:0]      w_mplr_n;
  logic               w_prev_n;
  logic               w_accept;
  logic               w_last;

  assign req_ready = (r_state == IDLE) & ~flush;
  assign busy      = (r_state != IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_last    = (r_cnt == CNT_W'(XLEN));

  // Flush kills a pending response so a same-cycle handshake never completes.
  assign rsp_valid = r_rsp_valid & ~flush;
  assign rsp_res   = r_res;
  assign rsp_tag   = r_tag;

  e203_dsp_booth_step #(.W(XLEN)) u_step (
    .i_acc   (r_acc),
    .i_mplr  (r_mplr),
    .i_prev  (r_prev),
    .i_mcand (r_mcand),
    .o_acc   (w_acc_n),
    .o_mplr  (w_mplr_n),
    .o_prev  (w_prev_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_n = CALC;
      CALC:    if (flush) w_state_n = IDLE;
               else if (w_last) w_state_n = DONE;
      DONE:    if (flush || rsp_ready) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mplr      <= '0;
      r_prev      <= 1'b0;
      r_mcand     <= '0;
      r_tag       <= '0;
      r_res       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= (w_state_n == DONE);
      if (w_accept) begin
        r_mcand <= req_rs1;
        r_mplr  <= req_rs2;
        r_tag   <= req_tag;
        r_acc   <= '0;
        r_prev  <= 1'b0;
        r_cnt   <= '0;
      end else if (r_state == CALC && !flush) begin
        r_acc  <= w_acc_n;
        r_mplr <= w_mplr_n;
        r_prev <= w_prev_n;
        r_cnt  <= r_cnt + CNT_W'(1);
        // {acc,mplr} holds the full product after the final step
        if (w_last) r_res <= {w_acc_n[XLEN-2:0], w_mplr_n};
      end
    end
  end

endmodule

// File: tb/tb_e203_exu_dsp_mul_srv.sv
// Directed-vector bench for the Booth multiplier responder.
module tb_e203_exu_dsp_mul_srv;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [32:0] req_rs1;
  logic [32:0] req_rs2;
  logic [4:0]  req_tag;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_res;
  logic [4:0]  rsp_tag;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  e203_exu_dsp_mul_srv dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_tag   (req_tag),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at +1 of the cycle after accept.
  task automatic send(input logic [32:0] a, input logic [32:0] b, input logic [4:0] t);
    req_rs1 = a; req_rs2 = b; req_tag = t; req_valid = 1'b1;
    #1;
    chk("req_ready_at_send", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [63:0] exp_res, input logic [4:0] exp_tag);
    int cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_latency"}, 64'(cyc), 64'd34);
    chk({name, "_res"}, rsp_res, exp_res);
    chk({name, "_tag"}, 64'(rsp_tag), 64'(exp_tag));
  endtask

  task automatic handshake(input string name);
    rsp_ready = 1'b1;
    #1;
    chk({name, "_ready_in_done"}, 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, "_valid_after_hs"}, 64'(rsp_valid), 64'd0);
    chk({name, "_busy_after_hs"}, 64'(busy), 64'd0);
  endtask

  task automatic watch_quiet(input string name, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    flush = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_res",   rsp_res,        64'd0);
    chk("rst_rsp_tag",   64'(rsp_tag),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1..T3: signed, zero-extended and extreme operands
    send(33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 5'd5);
    wait_rsp("t1", 64'h1, 5'd5);
    handshake("t1");
    send(33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 5'd6);
    wait_rsp("t2", 64'hFFFF_FFFE_0000_0001, 5'd6);
    handshake("t2");
    send(33'h1_8000_0000, 33'h1_8000_0000, 5'd10);
    wait_rsp("t3a", 64'h4000_0000_0000_0000, 5'd10);
    handshake("t3a");
    send(33'h0_7FFF_FFFF, 33'h1_FFFF_FFFE, 5'd31);
    wait_rsp("t3b", 64'hFFFF_FFFF_0000_0002, 5'd31);
    handshake("t3b");

    // T4: back-pressure with a competing request that must be ignored
    send(33'd3, 33'd5, 5'd9);
    wait_rsp("t4", 64'd15, 5'd9);
    req_rs1 = 33'd7; req_rs2 = 33'd7; req_tag = 5'd2; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t4_hold_res",   rsp_res,        64'd15);
      chk("t4_hold_tag",   64'(rsp_tag),   64'd9);
      chk("t4_hold_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("t4_no_accept_in_hs", 64'(busy), 64'd0);
    chk("t4_ready_after_hs",  64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t4_accept_after_bubble", 64'(busy), 64'd1);
    wait_rsp("t4b", 64'd49, 5'd2);
    handshake("t4b");

    // T5: flush mid-calculation
    send(33'd100, 33'd200, 5'd3);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("t5_ready_in_flush", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("t5_busy_after_flush",  64'(busy),      64'd0);
    chk("t5_ready_after_flush", 64'(req_ready), 64'd1);
    watch_quiet("t5_no_rsp", 40);
    send(33'd3, 33'd4, 5'd1);
    wait_rsp("t5b", 64'hC, 5'd1);
    handshake("t5b");

    // T6a: async reset mid-calculation
    send(33'd5, 33'd6, 5'd4);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy",      64'(busy),      64'd0);
    chk("t6_rst_valid",     64'(rsp_valid), 64'd0);
    chk("t6_rst_res",       rsp_res,        64'd0);
    chk("t6_rst_tag",       64'(rsp_tag),   64'd0);
    chk("t6_rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    watch_quiet("t6_no_rsp_after_rst", 40);

    // T6b: flush coincident with the response handshake
    send(33'h1_FFFF_FFFD, 33'd5, 5'd7);
    wait_rsp("t6b", 64'hFFFF_FFFF_FFFF_FFF1, 5'd7);
    rsp_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; flush = 1'b0;
    #1;
    chk("t6b_valid_after", 64'(rsp_valid), 64'd0);
    chk("t6b_busy_after",  64'(busy),      64'd0);
    chk("t6b_ready_after", 64'(req_ready), 64'd1);
    send(33'd6, 33'd7, 5'd8);
    wait_rsp("t6c", 64'd42, 5'd8);
    handshake("t6c");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
